full_adder_dataflow: RTL and testbench
======================================

// Module: full_adder_dataflow
// PURPOSE
//   Parameterised binary adder built from a ripple chain of 1-bit full-adder cells.
//   Sum/Cout are pure dataflow (continuous-assign) outputs with zero latency.
//   A registered copy (Sum_r/Cout_r/valid_r) is provided for pipelined consumers.
//   Default WIDTH=1 makes it a drop-in single-bit full adder for arithmetic datapaths.
// PARAMETERS
//   WIDTH     1   operand width in bits; must be >= 1
//   REG_OUT   1   1 = build registered outputs; 0 = registered outputs tied to 0
// PORTS
//   clk       in   1      single clock; rising edge samples the registered outputs
//   rst       in   1      asynchronous, active-high reset
//   A         in   WIDTH  operand A, unsigned
//   B         in   WIDTH  operand B, unsigned
//   Cin       in   1      carry in to bit 0
//   in_valid  in   1      qualifies A/B/Cin for the registered path
//   Sum       out  WIDTH  combinational sum, (A+B+Cin) mod 2^WIDTH
//   Cout      out  1      combinational carry out of the MSB
//   Sum_r     out  WIDTH  registered Sum
//   Cout_r    out  1      registered Cout
//   valid_r   out  1      registered in_valid
// BEHAVIOUR
//   - Cell equations, bit i:
//     s[i] = a^b^c[i]; c[i+1] = (a&b)|(a&c[i])|(b&c[i]); c[0] = Cin.
//   - {Cout,Sum} == A + B + Cin, computed at WIDTH+1 bits with no truncation.
//   - Combinational path: no dependence on clk or rst.
//     - Sum/Cout settle within the same time step as any input change.
//     - Valid with clk unconnected.
//   - Registered path, latency 1 cycle:
//     - On posedge clk with in_valid=1: Sum_r<=Sum, Cout_r<=Cout, valid_r<=1.
//     - On posedge clk with in_valid=0: Sum_r/Cout_r hold; valid_r<=0.
//   - Reset: while rst=1, Sum_r=0, Cout_r=0, valid_r=0 immediately, without waiting for clk.
//     - Reset asserted mid-operation discards the captured result.
//     - The first capture after release happens on the first posedge with rst=0.
//   - Reset has no effect on Sum/Cout.
//   - Boundaries:
//     - Full-scale A=B=2^WIDTH-1, Cin=1 -> Sum=all ones, Cout=1.
//     - All zeros -> Sum=0, Cout=0.
//   - X/Z on any input may propagate X to the outputs.
//     - No requirement beyond correctness on 0/1 inputs.
// STRUCTURE
//   - Sub-module fa_cell (a, b, cin -> s, cout): dataflow assigns only.
//     - Instantiated WIDTH times via generate, carry chained LSB to MSB.
//   - Top holds the generate loop, the carry vector c[WIDTH:0] and the output register block.
//   - No shared package required; WIDTH is the only configuration constant.
// TESTING
//   1. WIDTH=1, exhaustive 8 combos of A,B,Cin, 10 time units apart, clk idle:
//      {Cout,Sum} = 00,01,01,10,01,10,10,11 in the order 000..111.
//   2. WIDTH=8: A=8'hFF, B=8'h00, Cin=1 -> Sum=8'h00, Cout=1 (full carry ripple).
//      Then A=8'h5A, B=8'hA5, Cin=0 -> Sum=8'hFF, Cout=0.
//   3. Registered path, in_valid=1, A=1, B=1, Cin=1:
//      After one posedge: Sum_r=1, Cout_r=1, valid_r=1.
//      Drop in_valid: valid_r=0 next edge, Sum_r holds 1.
//   4. Async reset mid-operation, with Sum_r=1: pulse rst between clock edges.
//      Sum_r/Cout_r/valid_r = 0 within the same time step.
//      Sum/Cout unchanged.
//   5. WIDTH=8 random: 1000 random A/B/Cin vectors.
//      Check {Cout,Sum} == A+B+Cin every vector.
//      Check the registered outputs one cycle later.

Source files
------------

// File: rtl/full_adder_dataflow_pkg.sv
// Shared configuration defaults for the ripple-carry adder slice.
package full_adder_dataflow_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH   = 1;
  localparam bit          FA_DEFAULT_REG_OUT = 1'b1;

endpackage

// File: rtl/full_adder_dataflow_fa_cell.sv
// One-bit full-adder cell; pure dataflow, chained by the top into a ripple adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_dataflow.sv
// WIDTH-bit ripple-carry adder with a zero-latency combinational result and an
// optional one-cycle registered copy qualified by in_valid.
module full_adder_dataflow
  import full_adder_dataflow_pkg::*;
#(
  parameter int unsigned WIDTH   = FA_DEFAULT_WIDTH,
  parameter bit          REG_OUT = FA_DEFAULT_REG_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_r,
  output logic             Cout_r,
  output logic             valid_r
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign Sum  = s;
  assign Cout = c[WIDTH];

  // Valid-only interface: in_valid marks A/B/Cin as a result worth capturing;
  // there is no ready, so every qualified cycle is taken and valid_r echoes it.
  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_r_q, sum_r_d;
    logic             cout_r_q, cout_r_d;
    logic             valid_r_q, valid_r_d;

    always_comb begin
      sum_r_d   = sum_r_q;
      cout_r_d  = cout_r_q;
      valid_r_d = in_valid;
      if (in_valid) begin
        sum_r_d  = Sum;
        cout_r_d = Cout;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_r_q   <= '0;
        cout_r_q  <= 1'b0;
        valid_r_q <= 1'b0;
      end else begin
        sum_r_q   <= sum_r_d;
        cout_r_q  <= cout_r_d;
        valid_r_q <= valid_r_d;
      end
    end

    assign Sum_r   = sum_r_q;
    assign Cout_r  = cout_r_q;
    assign valid_r = valid_r_q;
  end else begin : g_noreg
    assign Sum_r   = '0;
    assign Cout_r  = 1'b0;
    assign valid_r = 1'b0;
  end

endmodule

// File: tb/tb_full_adder_dataflow.sv
// Directed and random checks of the ripple adder at WIDTH=1 and WIDTH=8.
module tb_full_adder_dataflow;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_en;
  logic rst;

  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
  end
  always #5 clk = clk_en ? ~clk : clk;

  // ---------------- DUT instances ----------------
  logic [0:0] a1, b1, sum1, sum1_r;
  logic       cin1, v1, cout1, cout1_r, valid1_r;
  logic [7:0] a8, b8, sum8, sum8_r;
  logic       cin8, v8, cout8, cout8_r, valid8_r;

  full_adder_dataflow #(.WIDTH(1), .REG_OUT(1'b1)) u_fa1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(v1),
    .Sum(sum1), .Cout(cout1), .Sum_r(sum1_r), .Cout_r(cout1_r), .valid_r(valid1_r)
  );

  full_adder_dataflow #(.WIDTH(8), .REG_OUT(1'b1)) u_fa8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .in_valid(v8),
    .Sum(sum8), .Cout(cout8), .Sum_r(sum8_r), .Cout_r(cout8_r), .valid_r(valid8_r)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];   // {valid, cout, sum[7:0]} pushed per driven vector

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic a, input logic b, input logic c, input logic v);
    a1 = a; b1 = b; cin1 = c; v1 = v;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    a8 = a; b8 = b; cin8 = c; v8 = v;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] exp1 [8];
  logic [8:0] full;
  logic [9:0] e;
  logic [7:0] exp_sum_r;
  logic       exp_cout_r;
  logic [7:0] ra, rb;
  logic       rc, rv;

  initial begin
    exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    #1;

    // reset state of the registered path
    check("rst_sum1_r",   sum1_r,   1'b0);
    check("rst_cout1_r",  cout1_r,  1'b0);
    check("rst_valid1_r", valid1_r, 1'b0);
    check("rst_sum8_r",   sum8_r,   8'h00);
    check("rst_valid8_r", valid8_r, 1'b0);

    // WIDTH=1 exhaustive, clock idle (reset held, which must not affect Sum/Cout)
    for (int i = 0; i < 8; i++) begin
      drive1(i[2], i[1], i[0], 1'b0);
      #10;
      check($sformatf("w1_combo%0d", i), {cout1, sum1}, exp1[i]);
    end

    // WIDTH=8 directed vectors
    drive8(8'hFF, 8'h00, 1'b1, 1'b0); #10;
    check("w8_ripple_sum",  sum8,  8'h00);
    check("w8_ripple_cout", cout8, 1'b1);
    drive8(8'h5A, 8'hA5, 1'b0, 1'b0); #10;
    check("w8_5a_a5_sum",   sum8,  8'hFF);
    check("w8_5a_a5_cout",  cout8, 1'b0);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b0); #10;
    check("w8_full_sum",    sum8,  8'hFF);
    check("w8_full_cout",   cout8, 1'b1);
    drive8(8'h00, 8'h00, 1'b0, 1'b0); #10;
    check("w8_zero_sum",    sum8,  8'h00);
    check("w8_zero_cout",   cout8, 1'b0);
    drive8(8'h80, 8'h80, 1'b0, 1'b0); #10;
    check("w8_msb_sum",     sum8,  8'h00);
    check("w8_msb_cout",    cout8, 1'b1);

    // release reset and start the clock
    rst = 1'b0;
    clk_en = 1'b1;
    tick();
    check("idle_valid1_r", valid1_r, 1'b0);

    // registered path
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("reg_sum1_r",   sum1_r,   1'b1);
    check("reg_cout1_r",  cout1_r,  1'b1);
    check("reg_valid1_r", valid1_r, 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("hold_valid1_r", valid1_r, 1'b0);
    check("hold_sum1_r",   sum1_r,   1'b1);
    check("hold_cout1_r",  cout1_r,  1'b1);

    // async reset between edges
    drive1(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_sum1_r",   sum1_r,   1'b0);
    check("arst_cout1_r",  cout1_r,  1'b0);
    check("arst_valid1_r", valid1_r, 1'b0);
    check("arst_comb",     {cout1, sum1}, 2'b10);
    drive1(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("arst_held_sum1_r",   sum1_r,   1'b0);
    check("arst_held_valid1_r", valid1_r, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    check("post_rst_sum1_r",   sum1_r,   1'b0);
    check("post_rst_cout1_r",  cout1_r,  1'b1);
    check("post_rst_valid1_r", valid1_r, 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 random with registered-path scoreboard
    exp_sum_r  = 8'h00;
    exp_cout_r = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      if (n == 0) begin
        ra = 8'hFF; rb = 8'hFF; rc = 1'b1; rv = 1'b1;
      end
      drive8(ra, rb, rc, rv);
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      exp_q.push_back({rv, full});
      #1;
      check("rnd_comb", {cout8, sum8}, full);
      tick();
      if (exp_q.size() == 0) begin
        check("rnd_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[9]) begin
          exp_sum_r  = e[7:0];
          exp_cout_r = e[8];
        end
        check("rnd_valid_r", valid8_r, e[9]);
        check("rnd_reg", {cout8_r, sum8_r}, {exp_cout_r, exp_sum_r});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
